// File: rtl/t07_mem_pkg.sv
// t07_mem_pkg: shared types and constants for the memory responder.
//   rwi_t        - CPU request type encoding
//   resp_state_t - responder FSM states
//   ERR_DATA_DEFAULT - data returned when a read/fetch times out
package t07_mem_pkg;
    typedef enum logic [1:0] {
        RWI_IDLE  = 2'b00,
        RWI_READ  = 2'b01,
        RWI_WRITE = 2'b10,
        RWI_FETCH = 2'b11
    } rwi_t;
    typedef enum logic [1:0] {IDLE, BUS, DONE} resp_state_t;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
endpackage

// File: rtl/t07_timeout_counter.sv
// t07_timeout_counter: saturating 16-bit bus-cycle counter with expiry flag.
//   clk, nrst - clock and asynchronous active-low reset
//   clear     - zero the count
//   enable    - count this cycle
//   limit     - number of enabled cycles allowed (1..65535)
//   expired   - high in the enabled cycle where count reaches limit-1
module t07_timeout_counter (
    input  logic        clk,
    input  logic        nrst,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] limit,
    output logic        expired
);
    logic [15:0] count;
    assign expired = enable && (count >= limit - 16'd1);
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) count <= '0;
        else if (clear) count <= '0;
        else if (enable && count != 16'hFFFF) count <= count + 16'd1;
    end
endmodule

// File: rtl/t07_mem_responder.sv
// t07_mem_responder: executes one CPU memory request as a Wishbone-classic transaction.
//   clk, nrst                 - clock and asynchronous active-low reset
//   rwi_i, addr_i, wdata_i    - CPU request (sampled only in IDLE)
//   busy_o, rdata_o           - in-flight flag and read/fetch result
//   fetch_o, err_o            - fetch-in-progress and timeout pulse
//   wb_*                      - Wishbone master signals
module t07_mem_responder
    import t07_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  rwi_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic [31:0] rdata_o,
    output logic        fetch_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);
    resp_state_t state, state_n;
    rwi_t        rwi_q, rwi_n;
    logic [31:0] adr_n, dat_n, rdata_n;
    logic        err_n, expired, rd;
    assign wb_sel_o = 4'hF;
    assign rd = (rwi_q == RWI_READ) || (rwi_q == RWI_FETCH);
    t07_timeout_counter u_tmo (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (state != BUS),
        .enable  (state == BUS),
        .limit   (16'(TIMEOUT_CYCLES)),
        .expired (expired)
    );
    // Ack is checked before expiry so a coinciding ack completes cleanly.
    always_comb begin
        state_n = state;
        rwi_n   = rwi_q;
        adr_n   = wb_adr_o;
        dat_n   = wb_dat_o;
        rdata_n = rdata_o;
        err_n   = 1'b0;
        case (state)
            IDLE: if (rwi_i != 2'b00) begin
                state_n = BUS;
                rwi_n   = rwi_t'(rwi_i);
                adr_n   = {addr_i[31:2], 2'b00};
                dat_n   = wdata_i;
            end
            BUS: if (wb_ack_i) begin
                state_n = DONE;
                rdata_n = rd ? wb_dat_i : rdata_o;
            end else if (expired) begin
                state_n = DONE;
                err_n   = 1'b1;
                rdata_n = rd ? ERR_DATA : rdata_o;
            end
            default: state_n = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            rwi_q    <= RWI_IDLE;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
            busy_o   <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            fetch_o  <= 1'b0;
        end else begin
            state    <= state_n;
            rwi_q    <= rwi_n;
            wb_adr_o <= adr_n;
            wb_dat_o <= dat_n;
            rdata_o  <= rdata_n;
            err_o    <= err_n;
            busy_o   <= state_n == BUS;
            wb_cyc_o <= state_n == BUS;
            wb_stb_o <= state_n == BUS;
            wb_we_o  <= (state_n == BUS) && (rwi_n == RWI_WRITE);
            fetch_o  <= (state_n == BUS) && (rwi_n == RWI_FETCH);
        end
    end
endmodule

// File: tb/tb_t07_mem_responder.sv
// tb_t07_mem_responder: directed table-driven bench for t07_mem_responder (TIMEOUT_CYCLES=8).
module tb_t07_mem_responder;
    logic        clk = 1'b0;
    logic        nrst;
    logic [1:0]  rwi_i;
    logic [31:0] addr_i, wdata_i, rdata_o, wb_adr_o, wb_dat_o, wb_dat_i;
    logic        busy_o, fetch_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [3:0]  wb_sel_o;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [1:0]  rwi;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;
        logic [31:0] ack_data;
        int          exp_busy;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_we;
        logic [31:0] exp_adr;
        int          exp_fetch;
    } vec_t;

    vec_t vecs[7];
    vec_t rec;

    t07_mem_responder #(.TIMEOUT_CYCLES(8)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .rwi_i    (rwi_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .busy_o   (busy_o),
        .rdata_o  (rdata_o),
        .fetch_o  (fetch_o),
        .err_o    (err_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v, input int idx);
        int cycles;
        int fetches;
        rwi_i = v.rwi; addr_i = v.addr; wdata_i = v.wdata; wb_ack_i = 1'b0;
        @(posedge clk); #1;
        rwi_i = 2'b00; addr_i = ~v.addr; wdata_i = ~v.wdata;
        cycles = 0;
        fetches = 0;
        while (busy_o && cycles < 64) begin
            wb_ack_i = (cycles == v.ack_at);
            wb_dat_i = v.ack_data;
            @(negedge clk);
            if (cycles == 0) begin
                chk($sformatf("v%0d_we", idx), 32'(wb_we_o), 32'(v.exp_we));
                chk($sformatf("v%0d_adr", idx), wb_adr_o, v.exp_adr);
                chk($sformatf("v%0d_sel", idx), 32'(wb_sel_o), 32'hF);
                chk($sformatf("v%0d_cycstb", idx), {30'd0, wb_cyc_o, wb_stb_o}, 32'h3);
                if (v.exp_we) chk($sformatf("v%0d_dat", idx), wb_dat_o, v.wdata);
            end
            fetches += int'(fetch_o);
            cycles++;
            @(posedge clk); #1;
        end
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        chk($sformatf("v%0d_busy_cycles", idx), 32'(cycles), 32'(v.exp_busy));
        chk($sformatf("v%0d_fetch_cycles", idx), 32'(fetches), 32'(v.exp_fetch));
        chk($sformatf("v%0d_rdata", idx), rdata_o, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), 32'(err_o), 32'(v.exp_err));
        chk($sformatf("v%0d_cyc_done", idx), 32'(wb_cyc_o), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_err_after", idx), 32'(err_o), 32'd0);
    endtask

    initial begin
        vecs[0] = '{2'b01, 32'h0000_1006, 32'h0,         2,    32'h1234_5678, 3, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_1004, 0};
        vecs[1] = '{2'b10, 32'h0000_0020, 32'hCAFE_F00D, 0,    32'hFFFF_0000, 1, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0020, 0};
        vecs[2] = '{2'b11, 32'h0000_0100, 32'h0,         1000, 32'h0,         8, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0100, 8};
        vecs[3] = '{2'b01, 32'h0000_0044, 32'h0,         7,    32'h0000_0055, 8, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0044, 0};
        vecs[4] = '{2'b10, 32'h0000_0007, 32'h1357_9BDF, 3,    32'h0BAD_0BAD, 4, 32'h0000_0055, 1'b0, 1'b1, 32'h0000_0004, 0};
        vecs[5] = '{2'b11, 32'h0000_0203, 32'h0,         0,    32'hA5A5_A5A5, 1, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0000_0200, 1};
        vecs[6] = '{2'b01, 32'hFFFF_FFFE, 32'h0,         6,    32'h0BAD_F00D, 7, 32'h0BAD_F00D, 1'b0, 1'b0, 32'hFFFF_FFFC, 0};
        nrst = 1'b0; rwi_i = 2'b00; addr_i = '0; wdata_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
        #12;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cycstbwe", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        chk("rst_fetch_err", {30'd0, fetch_o, err_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) run_req(vecs[i], i);
        // Ack while idle must be ignored.
        wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ack_busy", {30'd0, busy_o, wb_cyc_o}, 32'd0);
            @(posedge clk); #1;
        end
        wb_ack_i = 1'b0;
        chk("idle_ack_rdata", rdata_o, 32'h0BAD_F00D);
        // Asynchronous reset in the middle of a bus cycle.
        rwi_i = 2'b01; addr_i = 32'h80;
        @(posedge clk); #1;
        rwi_i = 2'b00;
        chk("midrst_busy_before", 32'(busy_o), 32'd1);
        @(posedge clk); #3;
        nrst = 1'b0;
        #1;
        chk("midrst_busy", {29'd0, busy_o, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("midrst_rdata", rdata_o, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(negedge clk);
        chk("midrst_no_replay", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        rec = '{2'b01, 32'h0000_0084, 32'h0, 1, 32'h0000_0077, 2, 32'h0000_0077, 1'b0, 1'b0, 32'h0000_0084, 0};
        run_req(rec, 7);
        // Fetch held continuously with zero-wait ack: one fetch every 3 cycles.
        rwi_i = 2'b11; wb_ack_i = 1'b1;
        for (int j = 0; j < 9; j++) begin
            addr_i = 32'h300 + 32'h1000 * j;
            wb_dat_i = 32'h1111_0000 + j;
            @(negedge clk);
            chk($sformatf("hold_busy_%0d", j), 32'(busy_o), 32'(j % 3 == 1));
            chk($sformatf("hold_fetch_%0d", j), 32'(fetch_o), 32'(j % 3 == 1));
            if (j % 3 == 1) chk($sformatf("hold_adr_%0d", j), wb_adr_o, 32'h300 + 32'h1000 * (j - 1));
            if (j % 3 == 2) chk($sformatf("hold_rdata_%0d", j), rdata_o, 32'h1111_0000 + j - 1);
            @(posedge clk); #1;
        end
        rwi_i = 2'b00; wb_ack_i = 1'b0;
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
